// File: rtl/sp_ram_arbiter_pkg.sv
// sp_ram_arbiter_pkg: shared types for the single-port RAM arbiter.
//   port_e      - requester identity (instruction fetch / data)
//   resp_t      - registered response state carried from grant to rvalid
//   RAM_LATENCY - read latency of the attached RAM, in cycles
package sp_ram_arbiter_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e owner;
    logic  err;
    logic  we;
  } resp_t;

  localparam int unsigned RAM_LATENCY = 1;

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// sp_ram_arbiter_if: OBI-style instruction-fetch and data request/response
// bundle between a core and the RAM arbiter.
//   master - core side: drives req/addr (and we/be/wdata on data),
//            receives gnt/rvalid/rdata/err
//   slave  - arbiter side: the mirror image
interface sp_ram_arbiter_if;

  logic        instr_req;
  logic        instr_gnt;
  logic [31:0] instr_addr;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata, instr_err,
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk_i, rst_i - clock, synchronous active-high reset
//   req[1:0]     - requests (bit 0 = instruction, bit 1 = data)
//   gnt[1:0]     - one-hot grant, combinational from req and the priority flop
// The priority flop names the port that wins a tie; after any grant it
// points at the other port. No grants are issued while rst_i is high.
module rr_arb2
  import sp_ram_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e prio_q;
  port_e prio_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= PORT_INSTR;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
    if (!rst_i) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio_q == PORT_INSTR) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
      if (gnt[0]) begin
        prio_d = PORT_DATA;
      end else if (gnt[1]) begin
        prio_d = PORT_INSTR;
      end
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: shares one single-port word RAM (1-cycle read latency,
// byte-enable writes) between an instruction-fetch and a data requester.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   bus           - slave side of the instruction/data request bundle
//   ram_en_o      - RAM enable, only for granted in-range accesses
//   ram_addr_o    - RAM word address (byte address [ADDR_WIDTH+1:2])
//   ram_we_o, ram_be_o, ram_wdata_o - write controls, zero when idle
//   ram_rdata_i   - RAM read data, valid one cycle after ram_en_o
// Every grant yields exactly one response on the same port one cycle later;
// out-of-range accesses skip the RAM and respond with err=1, rdata=0.
module sp_ram_arbiter
  import sp_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sp_ram_arbiter_if.slave       bus,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        any_gnt;
  port_e       sel;
  logic [31:0] sel_addr;
  logic        in_range;
  logic        sel_we;
  resp_t       resp_d;
  resp_t       resp_q;
  logic        rsp_live;
  logic [31:0] rsp_rdata;
  logic        unused_addr_bits;

  assign req = {bus.data_req, bus.instr_req};

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    any_gnt     = |gnt;
    sel         = gnt[1] ? PORT_DATA : PORT_INSTR;
    sel_addr    = (sel == PORT_DATA) ? bus.data_addr : bus.instr_addr;
    in_range    = (sel_addr[31:ADDR_WIDTH+2] == '0);
    sel_we      = (sel == PORT_DATA) && bus.data_we;

    ram_en_o    = any_gnt && in_range;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (ram_en_o) begin
      ram_addr_o  = sel_addr[ADDR_WIDTH+1:2];
      ram_we_o    = sel_we;
      ram_be_o    = (sel == PORT_DATA) ? bus.data_be : 4'hF;
      ram_wdata_o = (sel == PORT_DATA) ? bus.data_wdata : '0;
    end

    resp_d = '0;
    if (any_gnt) begin
      resp_d.valid = 1'b1;
      resp_d.owner = sel;
      resp_d.err   = !in_range;
      resp_d.we    = sel_we;
    end
  end

  // Word-aligned access: the byte offset never reaches the RAM.
  assign unused_addr_bits = ^sel_addr[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // The rst_i gate drops a response that was registered just before reset.
  always_comb begin
    rsp_live  = resp_q.valid && !rst_i;
    rsp_rdata = (rsp_live && !resp_q.err && !resp_q.we) ? ram_rdata_i : '0;

    bus.instr_gnt    = gnt[0];
    bus.data_gnt     = gnt[1];
    bus.instr_rvalid = rsp_live && (resp_q.owner == PORT_INSTR);
    bus.data_rvalid  = rsp_live && (resp_q.owner == PORT_DATA);
    bus.instr_err    = bus.instr_rvalid && resp_q.err;
    bus.data_err     = bus.data_rvalid && resp_q.err;
    bus.instr_rdata  = bus.instr_rvalid ? rsp_rdata : '0;
    bus.data_rdata   = bus.data_rvalid ? rsp_rdata : '0;
  end

  // Requesters keep a pending request stable until granted (withdrawal is allowed).
  instr_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.instr_req && !bus.instr_gnt) ##1 bus.instr_req |-> $stable(bus.instr_addr));

  data_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.data_req && !bus.data_gnt) ##1 bus.data_req |->
      $stable({bus.data_addr, bus.data_we, bus.data_be, bus.data_wdata}));

endmodule
